// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser between uart_rx and the watch control unit.
// Optional byte echo toward uart_tx is enabled by defining CMD_ECHO_EN.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
`ifdef CMD_ECHO_EN
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_busy,
`endif
  output logic [3:0] o_btn,
  output logic       o_mode,
  output logic       o_set_valid,
  output logic [4:0] o_set_hh,
  output logic [5:0] o_set_mm,
  output logic [5:0] o_set_ss,
  output logic       o_err
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       buf_q [MAX_LEN];
  logic [7:0]       buf_d [MAX_LEN];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       btn_q, btn_d;
  logic             mode_q, mode_d;
  logic             setv_q, setv_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d;
  logic [5:0]       ss_q, ss_d;
  logic             err_q, err_d;

  logic [7:0] ch;
  logic       is_term;
  logic       expire;
  logic [3:0] dig [6];
  logic       all_dig;
  logic [6:0] hh7, mm7, ss7;

  assign ch      = (i_rx_data >= 8'h61 && i_rx_data <= 8'h7A) ? i_rx_data - 8'h20 : i_rx_data;
  assign is_term = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
  assign expire  = (state_q != IDLE) && !i_rx_done && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Time-set field decode from buffer positions 1..6
  always_comb begin
    all_dig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dig[i] = 4'(buf_q[i+1] - 8'h30);
      if (buf_q[i+1] < 8'h30 || buf_q[i+1] > 8'h39) all_dig = 1'b0;
    end
    hh7 = 7'(dig[0]) * 7'd10 + 7'(dig[1]);
    mm7 = 7'(dig[2]) * 7'd10 + 7'(dig[3]);
    ss7 = 7'(dig[4]) * 7'd10 + 7'(dig[5]);
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    buf_d   = buf_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
    btn_d   = '0;
    mode_d  = 1'b0;
    setv_d  = 1'b0;
    err_d   = 1'b0;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    if (i_rx_done) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!is_term) begin
            buf_d[0] = ch;
            len_d    = LEN_W'(1);
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (is_term) begin
            len_d   = '0;
            state_d = IDLE;
            if (len_q == LEN_W'(1) && buf_q[0] == 8'h55)      btn_d = 4'b0001;
            else if (len_q == LEN_W'(1) && buf_q[0] == 8'h44) btn_d = 4'b0010;
            else if (len_q == LEN_W'(1) && buf_q[0] == 8'h4C) btn_d = 4'b0100;
            else if (len_q == LEN_W'(1) && buf_q[0] == 8'h52) btn_d = 4'b1000;
            else if (len_q == LEN_W'(1) && buf_q[0] == 8'h4D) mode_d = 1'b1;
            else if (len_q == LEN_W'(7) && buf_q[0] == 8'h54 && all_dig &&
                     hh7 < 7'd24 && mm7 < 7'd60 && ss7 < 7'd60) begin
              setv_d = 1'b1;
              hh_d   = 5'(hh7);
              mm_d   = 6'(mm7);
              ss_d   = 6'(ss7);
            end else begin
              err_d = 1'b1;
            end
          end else if (len_q < LEN_W'(MAX_LEN)) begin
            for (int i = 0; i < int'(MAX_LEN); i++)
              if (LEN_W'(i) == len_q) buf_d[i] = ch;
            len_d = len_q + LEN_W'(1);
          end else begin
            state_d = DISCARD;
          end
        end
        DISCARD: begin
          if (is_term) begin
            err_d   = 1'b1;
            len_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      err_d   = 1'b1;
      len_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(MAX_LEN); i++) buf_q[i] <= '0;
      btn_q   <= '0;
      mode_q  <= 1'b0;
      setv_q  <= 1'b0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      btn_q   <= btn_d;
      mode_q  <= mode_d;
      setv_q  <= setv_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      err_q   <= err_d;
    end
  end

  assign o_btn       = btn_q;
  assign o_mode      = mode_q;
  assign o_set_valid = setv_q;
  assign o_set_hh    = hh_q;
  assign o_set_mm    = mm_q;
  assign o_set_ss    = ss_q;
  assign o_err       = err_q;

`ifdef CMD_ECHO_EN
  // One-entry echo holder; bytes arriving while it is full are dropped
  logic       echo_vld_q, echo_vld_d;
  logic [7:0] echo_data_q, echo_data_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    echo_vld_d  = echo_vld_q;
    echo_data_d = echo_data_q;
    tx_start_d  = echo_vld_q && !i_tx_busy;
    tx_data_d   = tx_data_q;
    if (tx_start_d) begin
      tx_data_d  = echo_data_q;
      echo_vld_d = 1'b0;
    end else if (i_rx_done && !echo_vld_q) begin
      echo_vld_d  = 1'b1;
      echo_data_d = i_rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_vld_q  <= 1'b0;
      echo_data_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      echo_vld_q  <= echo_vld_d;
      echo_data_q <= echo_data_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser (MAX_LEN=8, TIMEOUT_CYC=100).
module tb_uart_cmd_parser;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned TO_CYC  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [3:0] o_btn;
  logic       o_mode, o_set_valid, o_err;
  logic [4:0] o_set_hh;
  logic [5:0] o_set_mm, o_set_ss;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       tx_busy = 1'b0;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int tx_pulses = 0;
  logic [7:0] last_tx = 8'h00;
  logic [3:0] s_btn;
  logic       s_mode, s_set, s_err;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
`ifdef CMD_ECHO_EN
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(tx_busy),
`endif
    .o_btn(o_btn), .o_mode(o_mode), .o_set_valid(o_set_valid),
    .o_set_hh(o_set_hh), .o_set_mm(o_set_mm), .o_set_ss(o_set_ss), .o_err(o_err)
  );

`ifndef CMD_ECHO_EN
  assign o_tx_data  = 8'h00;
  assign o_tx_start = 1'b0;
`endif

  always #5 clk = ~clk;

  // Count output pulse cycles and echo starts, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && (o_btn != 4'b0 || o_mode || o_set_valid || o_err)) pulses++;
    if (!rst && o_tx_start) begin
      tx_pulses++;
      last_tx = o_tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    s_btn  = o_btn;
    s_mode = o_mode;
    s_set  = o_set_valid;
    s_err  = o_err;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    total++; if (o_btn !== 4'b0) begin bad++; $display("FAIL reset_btn got %b want 0", o_btn); end
    total++; if (o_mode !== 1'b0 || o_set_valid !== 1'b0 || o_err !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got %b%b%b want 000", o_mode, o_set_valid, o_err); end
    total++; if (o_set_hh !== 5'd0 || o_set_mm !== 6'd0 || o_set_ss !== 6'd0) begin
      bad++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", o_set_hh, o_set_mm, o_set_ss); end
  endtask

  task automatic test_buttons;
    string      cmds [5] = '{"U\r", "d\r", "L\r", "r\n", "m\r"};
    logic [3:0] ebtn [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic       emod [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int p0;
    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      send_str(cmds[i]);
      total++; if (s_btn !== ebtn[i] || s_mode !== emod[i] || s_err !== 1'b0 || s_set !== 1'b0) begin
        bad++; $display("FAIL btn_%0d got btn=%b mode=%b err=%b set=%b want btn=%b mode=%b err=0 set=0",
                        i, s_btn, s_mode, s_err, s_set, ebtn[i], emod[i]); end
      total++; if (o_btn !== 4'b0 || o_mode !== 1'b0) begin
        bad++; $display("FAIL btn_width_%0d got btn=%b mode=%b one cycle later want 0", i, o_btn, o_mode); end
      total++; if (pulses - p0 !== 1) begin
        bad++; $display("FAIL btn_count_%0d got %0d pulses want 1", i, pulses - p0); end
    end
  endtask

  task automatic test_time_set;
    int p0;
    p0 = pulses;
    send_str("t123456\r");
    total++; if (s_set !== 1'b1 || s_err !== 1'b0) begin
      bad++; $display("FAIL set_pulse got set=%b err=%b want set=1 err=0", s_set, s_err); end
    total++; if (o_set_hh !== 5'd12 || o_set_mm !== 6'd34 || o_set_ss !== 6'd56) begin
      bad++; $display("FAIL set_value got %0d:%0d:%0d want 12:34:56", o_set_hh, o_set_mm, o_set_ss); end
    send_str("\n");
    total++; if (pulses - p0 !== 1) begin
      bad++; $display("FAIL set_lf_count got %0d pulses want 1", pulses - p0); end
  endtask

  task automatic test_bad_lines;
    string cmds [7] = '{"T245900\r", "T12a456\r", "T006000\r", "T12345\r", "X\r", "UU\r", "T1234567\r"};
    int p0;
    for (int i = 0; i < 7; i++) begin
      p0 = pulses;
      send_str(cmds[i]);
      total++; if (s_err !== 1'b1 || s_set !== 1'b0 || s_btn !== 4'b0 || s_mode !== 1'b0) begin
        bad++; $display("FAIL bad_%0d got err=%b set=%b btn=%b mode=%b want err only", i, s_err, s_set, s_btn, s_mode); end
      total++; if (pulses - p0 !== 1 || o_set_hh !== 5'd12 || o_set_mm !== 6'd34 || o_set_ss !== 6'd56) begin
        bad++; $display("FAIL bad_hold_%0d got pulses=%0d time=%0d:%0d:%0d want 1 12:34:56",
                        i, pulses - p0, o_set_hh, o_set_mm, o_set_ss); end
    end
    send_str("T235959\r");
    total++; if (s_set !== 1'b1 || o_set_hh !== 5'd23 || o_set_mm !== 6'd59 || o_set_ss !== 6'd59) begin
      bad++; $display("FAIL set_max got set=%b %0d:%0d:%0d want 1 23:59:59", s_set, o_set_hh, o_set_mm, o_set_ss); end
    send_str("T000000\r");
    total++; if (s_set !== 1'b1 || o_set_hh !== 5'd0 || o_set_mm !== 6'd0 || o_set_ss !== 6'd0) begin
      bad++; $display("FAIL set_min got set=%b %0d:%0d:%0d want 1 0:0:0", s_set, o_set_hh, o_set_mm, o_set_ss); end
  endtask

  task automatic test_overlong;
    int p0;
    p0 = pulses;
    send_str("ABCDEFGHIJ\r");
    total++; if (s_err !== 1'b1 || pulses - p0 !== 1) begin
      bad++; $display("FAIL overlong got err=%b pulses=%0d want 1 1", s_err, pulses - p0); end
    send_str("M\n");
    total++; if (s_mode !== 1'b1 || s_err !== 1'b0 || pulses - p0 !== 2) begin
      bad++; $display("FAIL after_overlong got mode=%b err=%b pulses=%0d want 1 0 2", s_mode, s_err, pulses - p0); end
  endtask

  task automatic test_timeout;
    int p0;
    int k;
    p0 = pulses;
    send_byte(8'h4C);
    k = 0;
    for (int i = 1; i <= 3 * TO_CYC; i++) begin
      @(posedge clk); #1;
      if (o_err) begin k = i; break; end
    end
    total++; if (k !== int'(TO_CYC)) begin
      bad++; $display("FAIL timeout_cycle got %0d want %0d (0 means never)", k, TO_CYC); end
    send_str("\r");
    total++; if (pulses - p0 !== 1 || s_btn !== 4'b0) begin
      bad++; $display("FAIL timeout_cr got pulses=%0d btn=%b want 1 0", pulses - p0, s_btn); end
    // Terminator lands in the very cycle the counter would expire
    p0 = pulses;
    send_byte(8'h4C);
    repeat (TO_CYC - 2) @(posedge clk);
    send_byte(8'h0D);
    total++; if (s_btn !== 4'b0100 || s_err !== 1'b0) begin
      bad++; $display("FAIL expiry_race got btn=%b err=%b want 0100 0", s_btn, s_err); end
    repeat (TO_CYC + 10) @(posedge clk);
    #1;
    total++; if (pulses - p0 !== 1) begin
      bad++; $display("FAIL idle_no_timeout got %0d pulses want 1", pulses - p0); end
  endtask

  task automatic test_reset_mid_line;
    int p0;
    send_str("T12");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_set_hh !== 5'd0 || o_err !== 1'b0) begin
      bad++; $display("FAIL mid_reset got hh=%0d err=%b want 0 0", o_set_hh, o_err); end
    rst = 1'b0;
    p0 = pulses;
    send_str("\r");
    total++; if (pulses - p0 !== 0) begin
      bad++; $display("FAIL mid_reset_cr got %0d pulses want 0", pulses - p0); end
    send_str("R\r");
    total++; if (s_btn !== 4'b1000 || pulses - p0 !== 1) begin
      bad++; $display("FAIL post_reset got btn=%b pulses=%0d want 1000 1", s_btn, pulses - p0); end
  endtask

`ifdef CMD_ECHO_EN
  task automatic test_echo;
    int t0;
    repeat (4) @(posedge clk);
    t0 = tx_pulses;
    tx_busy = 1'b1;
    send_byte(8'h61);
    send_byte(8'h62);
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx_pulses - t0 !== 0) begin
      bad++; $display("FAIL echo_busy got %0d starts want 0", tx_pulses - t0); end
    tx_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (tx_pulses - t0 !== 1 || last_tx !== 8'h61) begin
      bad++; $display("FAIL echo_release got starts=%0d data=%h want 1 61", tx_pulses - t0, last_tx); end
    send_str("\r");
    total++; if (s_err !== 1'b1) begin
      bad++; $display("FAIL echo_parse got err=%b want 1", s_err); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_buttons();
    test_time_set();
    test_bad_lines();
    test_overlong();
    test_timeout();
    test_reset_mid_line();
`ifdef CMD_ECHO_EN
    test_echo();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
